hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core: it produces the forwarding selects consumed by the execute stage's operand muxes and the decode-stage branch comparator, plus all stall and flush controls. The unit keeps its own shadow pipeline of source and destination register tags and write flags across the E, M and W stages, advancing in lockstep with the datapath pipeline registers. It sits beside the datapath, driven by decode-stage control and by the execute stage's write-address output.

## Interface
- No parameters.
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs_d, rt_d  input  5 each  decode-stage source register numbers
- use_rs_d, use_rt_d  input  1 each  decode instruction actually reads rs / rt
- reg_write_d  input  1  decode instruction writes the register file
- mem_to_reg_d  input  1  decode instruction is a load
- branch_d  input  1  decode instruction is a branch that compares rs/rt in D
- pc_src_d  input  1  branch/jump in D is taken
- reg_file_write_addr_e  input  5  destination register resolved by the execute stage this cycle
- md_busy_e  input  1  multi-cycle multiply/divide occupying E is not done
- forward_a_sel_e, forward_b_sel_e  output  2 each  execute operand mux selects: 00 register file, 01 result_w, 10 alu_result_m, 11 data_mem_read_data_m
- forward_a_d, forward_b_d  output  1 each  decode comparator takes alu_result_m instead of the register file
- stall_f, stall_d, stall_e  output  1 each  hold the PC / IF-ID register / ID-EX register
- flush_d, flush_e, flush_m  output  1 each  load a bubble into IF-ID / ID-EX / EX-MEM

## Operation
- Shadow state: E stage holds rs_e, rt_e, use_rs_e, use_rt_e, reg_write_e and mem_to_reg_e. M stage holds wa_m, reg_write_m and mem_to_reg_m. W stage holds wa_w and reg_write_w.
- Normal advance: D inputs load into E; wa_m loads from reg_file_write_addr_e; the E flags load into M; the M fields load into W.
- Register 0 never matches any tag and is never forwarded.
- Execute forwarding, operand A (B is identical using rt_e/use_rt_e):
  - If use_rs_e, reg_write_m and rs_e==wa_m: select 11 when mem_to_reg_m, else 10.
  - Otherwise, if use_rs_e, reg_write_w and rs_e==wa_w: select 01.
  - Otherwise select 00.
  - M has priority over W.
- A load in E followed by a dependent ALU op in D needs no stall: the dependent op is covered by select 11 on the next cycle.
- Decode forwarding: forward_a_d = branch_d & use_rs_d & reg_write_m & ~mem_to_reg_m & rs_d==wa_m. forward_b_d is the same using rt.
- branch_stall is asserted when branch_d and either of the following holds (for a used source matching the tag):
  - reg_write_e and the source equals reg_file_write_addr_e;
  - reg_write_m, mem_to_reg_m and the source equals wa_m.
- md_stall = md_busy_e.
- Stall and flush outputs:
  - md_stall: stall_f = stall_d = stall_e = 1 and flush_m = 1. E shadow holds; M receives a bubble (reg_write_m = 0, mem_to_reg_m = 0); W advances from M.
  - branch_stall without md_stall: stall_f = stall_d = 1 and flush_e = 1. E receives a bubble (reg_write_e = 0, mem_to_reg_e = 0, use flags = 0).
  - md_stall dominates: branch_stall is ignored while md_stall is 1.
- flush_d = pc_src_d & ~stall_d.
- All outputs are combinational from shadow state and current inputs; all shadow state is registered.

## Timing
- Reset: on rst at a rising edge, all shadow flags and tags clear to 0. While rst is high, every output is driven 0 regardless of the other inputs.
- After reset, with inputs idle, all outputs remain 0.
- Forward selects are valid in the same cycle the consumer is in E; there is zero added latency.
- A branch dependent on an ALU op in E stalls exactly 1 cycle, then uses forward_*_d=1.
- A branch dependent on a load stalls 2 cycles (load in E, then load in M), then reads the register file.
  - Write-before-read in the register file covers W.
- md_busy_e held for N cycles produces N stall cycles. The first cycle with md_busy_e=0 advances normally.
- Simultaneous pc_src_d and branch_stall: stall_d=1, so flush_d=0 and the branch re-evaluates next cycle.
- If rst is asserted mid-stall, the stall is abandoned; the next cycle shows all outputs at 0.

## Test plan
- Dependent ALU ops: add $3 (E) then M, followed by sub using $3 as rs -> forward_a_sel_e=10 in sub's E cycle; stall_f stays 0.
- Load forwarding: lw $4, with the consumer's rt=$4 one instruction behind -> forward_b_sel_e=11, no stall. With the consumer two instructions behind -> forward_b_sel_e=01.
- Priority and $0: M and W both write $5 -> select 10. A writer targeting $0 -> select 00.
- Branch hazards:
  - beq on $6 right after an add to $6 -> one cycle of stall_f=stall_d=flush_e=1, then forward_a_d=1.
  - beq right after lw $6 -> two stall cycles.
- Divide stall: md_busy_e high for 3 cycles -> stall_f/d/e=1 and flush_m=1 for 3 cycles. E tags are held; forwarding is correct afterwards.
- Reset: rst pulsed during a branch stall -> the next cycle has all outputs 0 and forward selects 00 until new writers propagate.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Decode/execute control bundle between the datapath and the hazard unit.
// The datapath drives the master side; the hazard unit is the slave.
interface hazard_unit_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       use_rs_d;
    logic       use_rt_d;
    logic       reg_write_d;
    logic       mem_to_reg_d;
    logic       branch_d;
    logic       pc_src_d;
    logic [4:0] reg_file_write_addr_e;
    logic       md_busy_e;
    logic [1:0] forward_a_sel_e;
    logic [1:0] forward_b_sel_e;
    logic       forward_a_d;
    logic       forward_b_d;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       flush_d;
    logic       flush_e;
    logic       flush_m;

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, reg_write_d, mem_to_reg_d,
               branch_d, pc_src_d, reg_file_write_addr_e, md_busy_e,
        input  forward_a_sel_e, forward_b_sel_e, forward_a_d, forward_b_d,
               stall_f, stall_d, stall_e, flush_d, flush_e, flush_m
    );

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, reg_write_d, mem_to_reg_d,
               branch_d, pc_src_d, reg_file_write_addr_e, md_busy_e,
        output forward_a_sel_e, forward_b_sel_e, forward_a_d, forward_b_d,
               stall_f, stall_d, stall_e, flush_d, flush_e, flush_m
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, stall and flush control for the five-stage MIPS pipeline,
// tracking register tags through a shadow E/M/W pipeline.
module hazard_unit (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    // Register 0 is hardwired, so it never produces a dependency.
    function automatic logic tag_hit(input logic [4:0] src, input logic used,
                                     input logic wr, input logic [4:0] dst);
        return used & wr & (src != 5'd0) & (src == dst);
    endfunction

    logic [4:0] rs_e_q, rs_e_d;
    logic [4:0] rt_e_q, rt_e_d;
    logic       use_rs_e_q, use_rs_e_d;
    logic       use_rt_e_q, use_rt_e_d;
    logic       reg_write_e_q, reg_write_e_d;
    logic       mem_to_reg_e_q, mem_to_reg_e_d;
    logic [4:0] wa_m_q, wa_m_d;
    logic       reg_write_m_q, reg_write_m_d;
    logic       mem_to_reg_m_q, mem_to_reg_m_d;
    logic [4:0] wa_w_q, wa_w_d;
    logic       reg_write_w_q, reg_write_w_d;

    logic       md_stall_s;
    logic       branch_stall_s;
    logic [1:0] fwd_a_e_s;
    logic [1:0] fwd_b_e_s;
    logic       fwd_a_d_s;
    logic       fwd_b_d_s;
    logic       stall_fd_s;
    logic       ld_in_m_s;
    logic       alu_in_m_s;

    function automatic logic [1:0] exec_sel(input logic [4:0] src, input logic used);
        logic [1:0] sel;
        if (tag_hit(src, used, reg_write_m_q, wa_m_q)) begin
            sel = mem_to_reg_m_q ? 2'b11 : 2'b10;
        end else if (tag_hit(src, used, reg_write_w_q, wa_w_q)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection; every output is forced low while reset is held.
    always_comb begin
        ld_in_m_s      = reg_write_m_q & mem_to_reg_m_q;
        alu_in_m_s     = reg_write_m_q & ~mem_to_reg_m_q;
        md_stall_s     = hz.md_busy_e;
        branch_stall_s = hz.branch_d &
            (tag_hit(hz.rs_d, hz.use_rs_d, reg_write_e_q, hz.reg_file_write_addr_e) |
             tag_hit(hz.rt_d, hz.use_rt_d, reg_write_e_q, hz.reg_file_write_addr_e) |
             tag_hit(hz.rs_d, hz.use_rs_d, ld_in_m_s, wa_m_q) |
             tag_hit(hz.rt_d, hz.use_rt_d, ld_in_m_s, wa_m_q));
        fwd_a_e_s      = exec_sel(rs_e_q, use_rs_e_q);
        fwd_b_e_s      = exec_sel(rt_e_q, use_rt_e_q);
        fwd_a_d_s      = hz.branch_d & tag_hit(hz.rs_d, hz.use_rs_d, alu_in_m_s, wa_m_q);
        fwd_b_d_s      = hz.branch_d & tag_hit(hz.rt_d, hz.use_rt_d, alu_in_m_s, wa_m_q);
        stall_fd_s     = md_stall_s | branch_stall_s;

        if (rst) begin
            hz.forward_a_sel_e = 2'b00;
            hz.forward_b_sel_e = 2'b00;
            hz.forward_a_d     = 1'b0;
            hz.forward_b_d     = 1'b0;
            hz.stall_f         = 1'b0;
            hz.stall_d         = 1'b0;
            hz.stall_e         = 1'b0;
            hz.flush_d         = 1'b0;
            hz.flush_e         = 1'b0;
            hz.flush_m         = 1'b0;
        end else begin
            hz.forward_a_sel_e = fwd_a_e_s;
            hz.forward_b_sel_e = fwd_b_e_s;
            hz.forward_a_d     = fwd_a_d_s;
            hz.forward_b_d     = fwd_b_d_s;
            hz.stall_f         = stall_fd_s;
            hz.stall_d         = stall_fd_s;
            hz.stall_e         = md_stall_s;
            hz.flush_d         = hz.pc_src_d & ~stall_fd_s;
            hz.flush_e         = branch_stall_s & ~md_stall_s;
            hz.flush_m         = md_stall_s;
        end
    end

    // Shadow pipeline next state: advance, E-bubble on branch stall, M-bubble on md stall.
    always_comb begin
        rs_e_d         = hz.rs_d;
        rt_e_d         = hz.rt_d;
        use_rs_e_d     = hz.use_rs_d;
        use_rt_e_d     = hz.use_rt_d;
        reg_write_e_d  = hz.reg_write_d;
        mem_to_reg_e_d = hz.mem_to_reg_d;
        wa_m_d         = hz.reg_file_write_addr_e;
        reg_write_m_d  = reg_write_e_q;
        mem_to_reg_m_d = mem_to_reg_e_q;
        wa_w_d         = wa_m_q;
        reg_write_w_d  = reg_write_m_q;
        if (md_stall_s) begin
            rs_e_d         = rs_e_q;
            rt_e_d         = rt_e_q;
            use_rs_e_d     = use_rs_e_q;
            use_rt_e_d     = use_rt_e_q;
            reg_write_e_d  = reg_write_e_q;
            mem_to_reg_e_d = mem_to_reg_e_q;
            reg_write_m_d  = 1'b0;
            mem_to_reg_m_d = 1'b0;
        end else if (branch_stall_s) begin
            rs_e_d         = 5'd0;
            rt_e_d         = 5'd0;
            use_rs_e_d     = 1'b0;
            use_rt_e_d     = 1'b0;
            reg_write_e_d  = 1'b0;
            mem_to_reg_e_d = 1'b0;
        end else begin
            rs_e_d         = hz.rs_d;
        end
    end

    // Shadow pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_e_q         <= 5'd0;
            rt_e_q         <= 5'd0;
            use_rs_e_q     <= 1'b0;
            use_rt_e_q     <= 1'b0;
            reg_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            wa_m_q         <= 5'd0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            wa_w_q         <= 5'd0;
            reg_write_w_q  <= 1'b0;
        end else begin
            rs_e_q         <= rs_e_d;
            rt_e_q         <= rt_e_d;
            use_rs_e_q     <= use_rs_e_d;
            use_rt_e_q     <= use_rt_e_d;
            reg_write_e_q  <= reg_write_e_d;
            mem_to_reg_e_q <= mem_to_reg_e_d;
            wa_m_q         <= wa_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            wa_w_q         <= wa_w_d;
            reg_write_w_q  <= reg_write_w_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized bench for hazard_unit: an instruction-level model of the E/M/W
// pipeline predicts forwarding, stall and flush controls every cycle.
module tb_hazard_unit;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        bit         urs;
        bit         urt;
        bit         wr;
        bit         ld;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if hz();
    hazard_unit dut (.clk(clk), .rst(rst), .hz(hz));

    instr_t e_i, m_i, w_i;
    instr_t bubble;
    int     n_vec = 0;
    int     n_bad = 0;
    int     md_left = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit depends(input logic [4:0] src, input bit u, input bit wr,
                                   input logic [4:0] dst);
        return u && wr && (src != 5'd0) && (src == dst);
    endfunction

    // Which producer supplies an E-stage operand: newest writer (M) first, then W.
    function automatic int exec_source(input logic [4:0] src, input bit u);
        if (depends(src, u, m_i.wr, m_i.dst)) return m_i.ld ? 3 : 2;
        if (depends(src, u, w_i.wr, w_i.dst)) return 1;
        return 0;
    endfunction

    function automatic bit branch_waits();
        logic [4:0] srcs [2];
        bit         uses [2];
        bit         w;
        srcs[0] = hz.rs_d; srcs[1] = hz.rt_d;
        uses[0] = hz.use_rs_d; uses[1] = hz.use_rt_d;
        w = 1'b0;
        for (int k = 0; k < 2; k++) begin
            // result not ready yet: producer still in E, or a load still in M
            if (depends(srcs[k], uses[k], e_i.wr, hz.reg_file_write_addr_e)) w = 1'b1;
            if (depends(srcs[k], uses[k], m_i.wr && m_i.ld, m_i.dst)) w = 1'b1;
        end
        return hz.branch_d && w;
    endfunction

    task automatic check_cycle();
        bit md, bs, stall;
        int ea, eb;
        bit da, db;
        md    = hz.md_busy_e;
        bs    = branch_waits();
        stall = md || bs;
        ea    = exec_source(e_i.rs, e_i.urs);
        eb    = exec_source(e_i.rt, e_i.urt);
        da    = hz.branch_d && depends(hz.rs_d, hz.use_rs_d, m_i.wr && !m_i.ld, m_i.dst);
        db    = hz.branch_d && depends(hz.rt_d, hz.use_rt_d, m_i.wr && !m_i.ld, m_i.dst);
        if (rst) begin
            ea = 0; eb = 0; da = 0; db = 0; md = 0; bs = 0; stall = 0;
        end
        check_val("fwd_a_e", 8'(hz.forward_a_sel_e), 8'(ea));
        check_val("fwd_b_e", 8'(hz.forward_b_sel_e), 8'(eb));
        check_val("fwd_a_d", 8'(hz.forward_a_d), 8'(da));
        check_val("fwd_b_d", 8'(hz.forward_b_d), 8'(db));
        check_val("stall_f", 8'(hz.stall_f), 8'(stall));
        check_val("stall_d", 8'(hz.stall_d), 8'(stall));
        check_val("stall_e", 8'(hz.stall_e), 8'(md));
        check_val("flush_d", 8'(hz.flush_d), 8'(!rst && hz.pc_src_d && !stall));
        check_val("flush_e", 8'(hz.flush_e), 8'(bs && !md));
        check_val("flush_m", 8'(hz.flush_m), 8'(md));
    endtask

    task automatic advance_model();
        instr_t nxt_e, nxt_m, nxt_w;
        bit md, bs;
        md = hz.md_busy_e;
        bs = branch_waits();
        nxt_w = m_i;
        nxt_m = e_i;
        nxt_m.dst = hz.reg_file_write_addr_e;
        nxt_e.rs = hz.rs_d; nxt_e.rt = hz.rt_d; nxt_e.dst = 5'd0;
        nxt_e.urs = hz.use_rs_d; nxt_e.urt = hz.use_rt_d;
        nxt_e.wr = hz.reg_write_d; nxt_e.ld = hz.mem_to_reg_d;
        if (md) begin
            nxt_e = e_i;
            nxt_m = bubble;
        end else if (bs) begin
            nxt_e = bubble;
        end
        if (rst) begin
            nxt_e = bubble; nxt_m = bubble; nxt_w = bubble;
        end
        e_i = nxt_e; m_i = nxt_m; w_i = nxt_w;
    endtask

    task automatic drive(input bit do_rst, input bit idle);
        rst = do_rst;
        if (idle) begin
            hz.rs_d = 5'd0; hz.rt_d = 5'd0; hz.use_rs_d = 1'b0; hz.use_rt_d = 1'b0;
            hz.reg_write_d = 1'b0; hz.mem_to_reg_d = 1'b0; hz.branch_d = 1'b0;
            hz.pc_src_d = 1'b0; hz.reg_file_write_addr_e = 5'd0; hz.md_busy_e = 1'b0;
            md_left = 0;
        end else begin
            // narrow register range keeps dependencies (and $0) frequent
            hz.rs_d                  = 5'($urandom_range(0, 3));
            hz.rt_d                  = 5'($urandom_range(0, 3));
            hz.use_rs_d              = 1'($urandom_range(0, 3) != 0);
            hz.use_rt_d              = 1'($urandom_range(0, 1));
            hz.reg_write_d           = 1'($urandom_range(0, 3) != 0);
            hz.mem_to_reg_d          = 1'($urandom_range(0, 2) == 0);
            hz.branch_d              = 1'($urandom_range(0, 2) == 0);
            hz.pc_src_d              = 1'($urandom_range(0, 1));
            hz.reg_file_write_addr_e = 5'($urandom_range(0, 3));
            if (md_left == 0 && $urandom_range(0, 11) == 0) md_left = $urandom_range(1, 4);
            hz.md_busy_e = (md_left > 0);
            if (md_left > 0) md_left--;
        end
    endtask

    task automatic run_cycle(input bit do_rst, input bit idle);
        drive(do_rst, idle);
        @(negedge clk);
        check_cycle();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bubble = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, urs: 1'b0, urt: 1'b0, wr: 1'b0, ld: 1'b0};
        e_i = bubble; m_i = bubble; w_i = bubble;
        // reset with busy inputs: outputs must stay low
        run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 59) == 0), 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
